io_port_ctrl: RTL

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

---
 rtl/io_pkg.sv | 14 +
 rtl/port_fifo.sv | 59 +++++
 rtl/io_port_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared constants for the IO port controller.
//   DATA_W / DEPTH : default port width and per-FIFO entry count
//   PTR_W / CNT_W  : FIFO pointer and occupancy widths for the defaults
//   ST_*           : interrupt FSM state encoding
package io_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_ASSERT     = 2'b01;
  localparam logic [1:0] ST_WAIT_DRAIN = 2'b10;
endpackage

// File: rtl/port_fifo.sv
// port_fifo: synchronous FIFO used for both port directions.
//   clk, rst (async active-low)
//   push/push_data : write request; accepted when not full, or when full
//                    with a same-cycle pop
//   pop            : read request; ignored when empty
//   head           : oldest entry, 0 when empty
//   full/empty/count : occupancy status
module port_fifo #(
  parameter  int DEPTH    = 4,
  parameter  int DATA_W   = 16,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = PTR_BITS + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                pop,
  output logic [DATA_W-1:0]   head,
  output logic                full,
  output logic                empty,
  output logic [CNT_BITS-1:0] count
);
  import io_pkg::*;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
  logic                do_push, do_pop;

  assign full    = (count == CNT_BITS'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this edge, so a full FIFO can still take a push.
  assign do_push = push & (~full | do_pop);
  // Empty FIFO never bypasses: head reads 0 until the word is stored.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is not reset; stale contents are masked by count/empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: CPU IN/OUT port controller with device-side valid/ready
// channels, an input-arrival interrupt and a sticky output-drop flag.
//   clk, rst (async active-low)
//   cpu_out_wr/cpu_out_data : OUT instruction write into output FIFO
//   cpu_in_rd/cpu_in_data   : IN instruction read from input FIFO head
//   dev_in_*                : device -> CPU stream into input FIFO
//   dev_out_*               : output FIFO -> device stream
//   interrupt/int_ack       : request raised when input data arrives
//   out_overflow            : sticky, an OUT write was dropped
//   in_count                : input FIFO occupancy
module io_port_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_out_wr,
  input  logic [DATA_W-1:0]       cpu_out_data,
  input  logic                    cpu_in_rd,
  output logic [DATA_W-1:0]       cpu_in_data,
  input  logic                    dev_in_valid,
  input  logic [DATA_W-1:0]       dev_in_data,
  output logic                    dev_in_ready,
  output logic                    dev_out_valid,
  output logic [DATA_W-1:0]       dev_out_data,
  input  logic                    dev_out_ready,
  output logic                    interrupt,
  input  logic                    int_ack,
  output logic                    out_overflow,
  output logic [$clog2(DEPTH):0]  in_count
);
  import io_pkg::*;

  localparam int CNT_BITS = $clog2(DEPTH) + 1;

  logic                in_full, in_empty, in_push;
  logic                out_full, out_empty;
  logic [CNT_BITS-1:0] out_count;
  logic [1:0]          state, state_nxt;
  logic                unused_ok;

  // Input side only pushes on a real handshake; a full input FIFO with a
  // same-cycle CPU read still refuses the word because ready was low.
  assign dev_in_ready = ~in_full;
  assign in_push      = dev_in_valid & dev_in_ready;

  port_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_push),
    .push_data (dev_in_data),
    .pop       (cpu_in_rd),
    .head      (cpu_in_data),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count)
  );

  port_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cpu_out_wr),
    .push_data (cpu_out_data),
    .pop       (dev_out_ready),
    .head      (dev_out_data),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  assign dev_out_valid = ~out_empty;
  assign unused_ok     = ^{in_empty, out_count};

  // Full implies non-empty, so dev_out_ready alone means a pop this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      out_overflow <= 1'b0;
    else if (cpu_out_wr && out_full && !dev_out_ready) out_overflow <= 1'b1;
  end

  // Interrupt FSM: one request per burst; pushes while waiting for the
  // FIFO to drain do not re-raise it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (in_count != '0) state_nxt = ST_ASSERT;
      ST_ASSERT:     if (int_ack)        state_nxt = ST_WAIT_DRAIN;
      ST_WAIT_DRAIN: if (in_count == '0) state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  assign interrupt = (state == ST_ASSERT);
endmodule
